// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module   : free_list
// Purpose  : Circular FIFO of unallocated physical register IDs for rename;
//            pops up to N per cycle, accepts N retirements, head checkpoints.
// Revision : 1.0 - initial release
// ============================================================================
module free_list #(
  parameter int N           = 3,
  parameter int PHYS_REGS   = 64,
  parameter int ARCH_REGS   = 32,
  parameter int CAP         = PHYS_REGS - ARCH_REGS,
  parameter int IDX_BITS    = $clog2(PHYS_REGS),
  parameter int SCALAR_BITS = $clog2(N + 1),
  parameter int PTR_BITS    = $clog2(CAP) + 1,
  parameter int CNT_BITS    = $clog2(CAP + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [SCALAR_BITS-1:0]       alloc_count,
  output logic [N-1:0][IDX_BITS-1:0]   free_regs,
  output logic [SCALAR_BITS-1:0]       num_avail,
  output logic [CNT_BITS-1:0]          free_count,
  input  logic [SCALAR_BITS-1:0]       retire_count,
  input  logic [N-1:0][IDX_BITS-1:0]   retire_regs,
  output logic [PTR_BITS-1:0]          checkpoint_head,
  input  logic                         restore_valid,
  input  logic [PTR_BITS-1:0]          restore_head
);

  localparam int c_SLOT_BITS = PTR_BITS - 1;
  localparam int c_WIDE      = CNT_BITS + 1;

  logic [IDX_BITS-1:0]    r_entries [CAP];
  logic [PTR_BITS-1:0]    r_head;
  logic [PTR_BITS-1:0]    r_tail;
  logic [PTR_BITS-1:0]    w_count;
  logic [SCALAR_BITS-1:0] w_eff_alloc;
  logic [c_WIDE-1:0]      w_next_count;

  // Outputs depend only on registered state.
  always_comb begin
    w_count = r_tail - r_head;
    free_count = CNT_BITS'(w_count);
    if (w_count >= PTR_BITS'(N)) num_avail = SCALAR_BITS'(N);
    else                         num_avail = w_count[SCALAR_BITS-1:0];
    w_eff_alloc = (alloc_count > num_avail) ? num_avail : alloc_count;
    w_next_count = c_WIDE'(w_count) - c_WIDE'(w_eff_alloc) + c_WIDE'(retire_count);
    checkpoint_head = r_head;
    for (int i = 0; i < N; i++) begin
      free_regs[i] = r_entries[c_SLOT_BITS'(r_head + PTR_BITS'(i))];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < CAP; i++) begin
        r_entries[i] <= IDX_BITS'(ARCH_REGS + i);
      end
      r_head <= '0;
      r_tail <= PTR_BITS'(CAP);
    end else begin
      // A restore rewinds the head; retirement still lands at the tail.
      r_head <= restore_valid ? restore_head : r_head + PTR_BITS'(w_eff_alloc);
      r_tail <= r_tail + PTR_BITS'(retire_count);
      for (int j = 0; j < N; j++) begin
        if (j < int'(retire_count)) begin
          r_entries[c_SLOT_BITS'(r_tail + PTR_BITS'(j))] <= retire_regs[j];
        end
      end
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    restore_valid || (w_next_count <= c_WIDE'(CAP)));

endmodule
`default_nettype wire
